// File: rtl/nv_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nv_fifo_pkg
// Purpose  : Shared geometry and helpers for the 128x18 RAM FIFO controller.
//            This covers RAM depth, payload width, address width and the
//            occupancy-counter width (0..DEPTH inclusive).
// Revision : 1.0 - initial release
// ============================================================================
package nv_fifo_pkg;

  localparam int DEPTH = 128;
  localparam int WIDTH = 18;
  localparam int AW    = 7;
  // The occupancy counter has to represent DEPTH itself, so it needs one extra bit.
  localparam int CW    = AW + 1;

  typedef logic [WIDTH-1:0] payload_t;
  typedef logic [AW-1:0]    ptr_t;
  typedef logic [CW-1:0]    cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  // Pointer advance. DEPTH is a power of two, so natural overflow gives the wrap.
  function automatic ptr_t ptr_next(input ptr_t p, input logic adv);
    return adv ? p + ptr_t'(1) : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nv_ram_fifo_ctrl_128x18_if.sv
`default_nettype none
// ============================================================================
// Module   : nv_ram_fifo_ctrl_128x18_if
// Purpose  : Producer/consumer valid-ready handshake bundle for the RAM FIFO.
//            The slave modport is the FIFO side. The master modport is the
//            side that owns the producer stream and the consumer ready.
// Revision : 1.0 - initial release
// ============================================================================
interface nv_ram_fifo_ctrl_128x18_if;
  import nv_fifo_pkg::*;

  logic     wr_pvld;
  logic     wr_prdy;
  payload_t wr_pd;
  logic     rd_pvld;
  logic     rd_prdy;
  payload_t rd_pd;

  modport master (
    output wr_pvld,
    output wr_pd,
    input  wr_prdy,
    input  rd_pvld,
    output rd_prdy,
    input  rd_pd
  );

  modport slave (
    input  wr_pvld,
    input  wr_pd,
    output wr_prdy,
    output rd_pvld,
    input  rd_prdy,
    output rd_pd
  );

endinterface
`default_nettype wire

// File: rtl/nv_fifo_skid2.sv
`default_nettype none
// ============================================================================
// Module   : nv_fifo_skid2
// Purpose  : Two-entry output skid buffer with bypass. RAM read data arrives
//            one cycle after issue. It goes straight to the consumer when the
//            skid is empty and the consumer takes it. Otherwise it is parked
//            behind any older entries.
// Revision : 1.0 - initial release
// ============================================================================
module nv_fifo_skid2
  import nv_fifo_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_vld,
  input  payload_t in_pd,
  input  logic     rd_prdy,
  output logic     rd_pvld,
  output payload_t rd_pd,
  output logic [1:0] skid_occ
);

  logic [1:0] occ_q, occ_d;
  payload_t   ent0_q, ent0_d;
  payload_t   ent1_q, ent1_d;
  logic       pop;
  logic       take_head;
  logic       store;
  logic [1:0] occ_rem;

  // Consumer view: the oldest skid entry wins; otherwise bypass the arriving RAM word.
  always_comb begin
    rd_pvld = (occ_q != 2'd0) | in_vld;
    if (occ_q != 2'd0) begin
      rd_pd = ent0_q;
    end else if (in_vld) begin
      rd_pd = in_pd;
    end else begin
      // Payload reads as zero while nothing is valid.
      rd_pd = '0;
    end
    pop = rd_pvld & rd_prdy;
  end

  // Entry bookkeeping: retire the head on pop, then append the arriving word unless it was bypassed.
  always_comb begin
    take_head = pop & (occ_q != 2'd0);
    store     = in_vld & ~(pop & (occ_q == 2'd0));
    occ_rem   = occ_q - {1'b0, take_head};
    ent0_d    = take_head ? ent1_q : ent0_q;
    ent1_d    = ent1_q;
    if (store) begin
      if (occ_rem == 2'd0) begin
        ent0_d = in_pd;
      end else begin
        ent1_d = in_pd;
      end
    end
    occ_d = occ_rem + {1'b0, store};
  end

  // Skid state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign skid_occ = occ_q;

endmodule
`default_nettype wire

// File: rtl/nv_ram_fifo_ctrl_128x18.sv
`default_nettype none
// ============================================================================
// Module   : nv_ram_fifo_ctrl_128x18
// Purpose  : Valid/ready FIFO controller for a 128x18 two-port RAM with a
//            one-cycle registered read. It owns the RAM write/read pins and
//            prefetches into a 2-entry skid so that back-to-back streaming
//            runs without bubbles.
// Revision : 1.0 - initial release
// ============================================================================
module nv_ram_fifo_ctrl_128x18
  import nv_fifo_pkg::*;
(
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  nv_ram_fifo_ctrl_128x18_if.slave  bus,
  output logic [CW-1:0]             wr_count,
  output logic                      ram_we,
  output logic [AW-1:0]             ram_wa,
  output logic [WIDTH-1:0]          ram_di,
  output logic                      ram_re,
  output logic [AW-1:0]             ram_ra,
  input  logic [WIDTH-1:0]          ram_dout,
  input  logic [31:0]               pwrbus_ram_pd,
  output logic [31:0]               ram_pwrbus_ram_pd
);

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       ram_cnt_q, ram_cnt_d;
  cnt_t       wr_count_q, wr_count_d;
  logic       inflight_q, inflight_d;

  logic       wr_prdy;
  logic       push;
  logic       pop;
  logic       issue;
  logic       rd_pvld;
  payload_t   rd_pd;
  logic [1:0] skid_occ;
  logic [2:0] pend;

  // Handshake decode and read-issue decision.
  always_comb begin
    // Ready depends only on the registered count, so there is no input-to-ready path.
    wr_prdy = (wr_count_q != FULL_CNT);
    push    = bus.wr_pvld & wr_prdy;
    pop     = rd_pvld & bus.rd_prdy;
    // Pop implies skid_occ + inflight >= 1, so this difference never underflows.
    pend    = 3'(skid_occ) + 3'(inflight_q) - 3'(pop);
    // The registered ram_cnt keeps a word written this cycle unissuable until the next one.
    issue   = (ram_cnt_q != '0) & (pend < 3'd2);
  end

  // Next-state for pointers, RAM occupancy, in-flight flag and total occupancy.
  always_comb begin
    wr_ptr_d   = ptr_next(wr_ptr_q, push);
    rd_ptr_d   = ptr_next(rd_ptr_q, issue);
    ram_cnt_d  = ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
    wr_count_d = wr_count_q + cnt_t'(push) - cnt_t'(pop);
    inflight_d = issue;
  end

  // Control state registers; reset drops all stored contents immediately.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      wr_count_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      wr_count_q <= wr_count_d;
      inflight_q <= inflight_d;
    end
  end

  // The RAM word read last cycle feeds the skid, which also covers the bypass path.
  nv_fifo_skid2 u_skid (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .in_vld   (inflight_q),
    .in_pd    (ram_dout),
    .rd_prdy  (bus.rd_prdy),
    .rd_pvld  (rd_pvld),
    .rd_pd    (rd_pd),
    .skid_occ (skid_occ)
  );

  assign bus.wr_prdy = wr_prdy;
  assign bus.rd_pvld = rd_pvld;
  assign bus.rd_pd   = rd_pd;

  // Addresses always show the live pointers; the enables qualify them.
  assign ram_we            = push;
  assign ram_wa            = wr_ptr_q;
  assign ram_di            = bus.wr_pd;
  assign ram_re            = issue;
  assign ram_ra            = rd_ptr_q;
  assign wr_count          = wr_count_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_fifo_ctrl_128x18.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_ram_fifo_ctrl_128x18
// Purpose  : Self-checking bench for the 128x18 RAM FIFO controller. It
//            includes a behavioural RAM, a queue-based reference model, a
//            scoreboard monitor and a table of cycle-exact directed
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nv_ram_fifo_ctrl_128x18;
  import nv_fifo_pkg::*;

  localparam int K_CNT    = 0;  // wr_count == val
  localparam int K_RE     = 1;  // ram_re == 1 and ram_ra == val
  localparam int K_PVLD   = 2;  // rd_pvld == 1 and rd_pd == val
  localparam int K_STREAM = 3;  // rd_pvld == 1 and wr_count <= 2

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_128x18_if bus_if();

  logic [CW-1:0]    wr_count;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_wa;
  logic [AW-1:0]    ram_ra;
  logic [WIDTH-1:0] ram_di;
  logic [WIDTH-1:0] ram_dout = '0;
  logic [31:0]      pwrbus;
  logic [31:0]      ram_pwrbus;

  nv_ram_fifo_ctrl_128x18 dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .bus               (bus_if),
    .wr_count          (wr_count),
    .ram_we            (ram_we),
    .ram_wa            (ram_wa),
    .ram_di            (ram_di),
    .ram_re            (ram_re),
    .ram_ra            (ram_ra),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus),
    .ram_pwrbus_ram_pd (ram_pwrbus)
  );

  // Two-port RAM with a one-cycle registered read.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  // Counters and model state (owned by the monitor).
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_cnt = 0;
  int pushed = 0;
  int issued = 0;
  int popped = 0;
  int dtab_i = 0;
  logic final_done = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  // Shared with the monitor, written by stimulus only.
  typedef struct { int cyc; int kind; int val; } dexp_t;
  dexp_t dtab [512];
  int    dtab_n = 0;
  int    tmo_events = 0;
  logic  final_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle, compares against the reference model.
  initial begin : mon
    logic exp_push;
    logic pop;
    logic [WIDTH-1:0] hd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_wr_prdy",  32'(bus_if.wr_prdy), 32'd1);
        chk("rst_rd_pvld",  32'(bus_if.rd_pvld), 32'd0);
        chk("rst_rd_pd",    32'(bus_if.rd_pd),   32'd0);
        chk("rst_wr_count", 32'(wr_count),       32'd0);
        chk("rst_ram_we",   32'(ram_we),         32'd0);
        chk("rst_ram_re",   32'(ram_re),         32'd0);
        chk("rst_ram_wa",   32'(ram_wa),         32'd0);
        chk("rst_ram_ra",   32'(ram_ra),         32'd0);
        model_cnt = 0; pushed = 0; issued = 0; popped = 0;
        exp_q.delete();
      end else begin
        chk("pwrbus_fwd", ram_pwrbus, pwrbus);
        chk("wr_count", 32'(wr_count), 32'(model_cnt));
        chk("wr_prdy", 32'(bus_if.wr_prdy), (model_cnt != DEPTH) ? 32'd1 : 32'd0);
        exp_push = bus_if.wr_pvld && (model_cnt != DEPTH);
        chk("ram_we", 32'(ram_we), 32'(exp_push));
        chk("ram_wa", 32'(ram_wa), 32'(pushed % DEPTH));
        chk("ram_ra", 32'(ram_ra), 32'(issued % DEPTH));
        if (exp_push) chk("ram_di", 32'(ram_di), 32'(bus_if.wr_pd));
        if (model_cnt == 0) chk("empty_rd_pvld", 32'(bus_if.rd_pvld), 32'd0);
        pop = bus_if.rd_pvld && bus_if.rd_prdy;
        if (ram_re) begin
          chk("re_has_data", ((pushed - issued) > 0) ? 32'd1 : 32'd0, 32'd1);
          chk("re_skid_room", ((issued - popped - int'(pop)) < 2) ? 32'd1 : 32'd0, 32'd1);
        end
        if (pop) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
          end else begin
            hd = exp_q.pop_front();
            chk("rd_pd_order", 32'(bus_if.rd_pd), 32'(hd));
          end
        end
        while (dtab_i < dtab_n && dtab[dtab_i].cyc == cyc) begin
          case (dtab[dtab_i].kind)
            K_CNT: chk("dir_wr_count", 32'(wr_count), dtab[dtab_i].val);
            K_RE: begin
              chk("dir_ram_re", 32'(ram_re), 32'd1);
              chk("dir_ram_ra", 32'(ram_ra), dtab[dtab_i].val);
            end
            K_PVLD: begin
              chk("dir_rd_pvld", 32'(bus_if.rd_pvld), 32'd1);
              chk("dir_rd_pd", 32'(bus_if.rd_pd), dtab[dtab_i].val);
            end
            K_STREAM: begin
              chk("stream_rd_pvld", 32'(bus_if.rd_pvld), 32'd1);
              chk("stream_wr_count_le2", (wr_count <= CW'(2)) ? 32'd1 : 32'd0, 32'd1);
            end
            default: ;
          endcase
          dtab_i++;
        end
        if (exp_push) exp_q.push_back(bus_if.wr_pd);
        model_cnt = model_cnt + int'(exp_push) - int'(pop);
        pushed    = pushed + int'(exp_push);
        issued    = issued + int'(ram_re);
        popped    = popped + int'(pop);
        if (final_req && !final_done) begin
          chk("timeouts", 32'(tmo_events), 32'd0);
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
          chk("directed_all_reached", 32'(dtab_i), 32'(dtab_n));
          final_done = 1'b1;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input int c, input int k, input int v);
    dtab[dtab_n] = '{c, k, v};
    dtab_n++;
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    while (((wr_count != '0) || bus_if.rd_pvld) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      tmo_events++;
      $display("FAIL drain_timeout: wr_count=%0d, expected 0", wr_count);
    end
  endtask

  // Stimulus.
  initial begin : stim
    int   c0;
    int   acc;
    int   k;
    logic acc_now;
    rst_n          = 1'b0;
    bus_if.wr_pvld = 1'b0;
    bus_if.wr_pd   = '0;
    bus_if.rd_prdy = 1'b0;
    pwrbus         = 32'hA5C3_0F1E;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single word into an empty FIFO: issue at N+1, bypassed data at N+2.
    c0 = cyc;
    add_exp(c0,     K_CNT,  0);
    add_exp(c0 + 1, K_RE,   0);
    add_exp(c0 + 1, K_CNT,  1);
    add_exp(c0 + 2, K_PVLD, 32'h2A5A5);
    add_exp(c0 + 2, K_CNT,  1);
    add_exp(c0 + 3, K_CNT,  0);
    bus_if.wr_pvld = 1'b1;
    bus_if.wr_pd   = 18'h2A5A5;
    bus_if.rd_prdy = 1'b1;
    tick();
    bus_if.wr_pvld = 1'b0;
    repeat (4) tick();

    // Fill to full with the consumer stalled; the last two offers are refused.
    bus_if.rd_prdy = 1'b0;
    for (int v = 0; v < 130; v++) begin
      bus_if.wr_pvld = 1'b1;
      bus_if.wr_pd   = 18'(v);
      tick();
    end
    bus_if.wr_pvld = 1'b0;
    add_exp(cyc, K_CNT, DEPTH);
    tick();
    bus_if.rd_prdy = 1'b1;
    wait_empty(400);

    // Refill across the address wrap while draining.
    for (int i = 0; i < 200; i++) begin
      bus_if.wr_pvld = 1'b1;
      bus_if.wr_pd   = 18'(1000 + i);
      tick();
    end
    bus_if.wr_pvld = 1'b0;
    wait_empty(400);

    // Full-rate streaming: no bubbles after the two-cycle fill.
    c0 = cyc;
    for (int j = 2; j < 302; j++) add_exp(c0 + j, K_STREAM, 0);
    for (int i = 0; i < 300; i++) begin
      bus_if.wr_pvld = 1'b1;
      bus_if.wr_pd   = 18'(i);
      bus_if.rd_prdy = 1'b1;
      tick();
    end
    bus_if.wr_pvld = 1'b0;
    wait_empty(50);

    // Random producer and consumer backpressure for 10k accepted words.
    acc = 0;
    k   = 0;
    while (acc < 10000 && k < 40000) begin
      bus_if.wr_pvld = (($urandom % 100) < 70);
      bus_if.wr_pd   = 18'($urandom);
      bus_if.rd_prdy = 1'($urandom % 2);
      if (($urandom % 64) == 0) pwrbus = $urandom;
      acc_now = bus_if.wr_pvld && bus_if.wr_prdy;
      tick();
      if (acc_now) acc++;
      k++;
    end
    if (acc < 10000) begin
      tmo_events++;
      $display("FAIL random_accept_budget: accepted %0d, expected 10000", acc);
    end
    bus_if.wr_pvld = 1'b0;
    bus_if.rd_prdy = 1'b1;
    wait_empty(400);

    // Reset mid-stream with 50 words stored; pulse lies between clock edges.
    bus_if.rd_prdy = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus_if.wr_pvld = 1'b1;
      bus_if.wr_pd   = 18'(500 + i);
      tick();
    end
    bus_if.wr_pvld = 1'b0;
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    tick();
    add_exp(cyc, K_CNT, 0);
    bus_if.wr_pvld = 1'b1;
    bus_if.wr_pd   = 18'h30F0F;
    bus_if.rd_prdy = 1'b1;
    tick();
    bus_if.wr_pvld = 1'b0;
    wait_empty(20);

    final_req = 1'b1;
    k = 0;
    while (!final_done && k < 10) begin
      tick();
      k++;
    end
    if (!final_done) $display("FAIL final_check: not reached, expected reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nv_ram_fifo_ctrl_128x18.md
# nv_ram_fifo_ctrl_128x18

Valid/ready FIFO controller that fronts a 128-entry × 18-bit two-port RAM. The RAM has a 1-cycle registered-read latency, and the controller drives its write port and read port. It accepts a producer stream, stores it in the RAM, and prefetches into a 2-entry output skid so that full-rate streaming needs no bubbles. It is the stage that owns the RAM's ra/re/wa/we/di pins and consumes its dout.

## Interface
- `DEPTH`, 128: RAM entries.
- `WIDTH`, 18: payload width.
- `AW`, 7: RAM address width (log2 DEPTH).
- `nvdla_core_clk` in 1: sole clock.
- `nvdla_core_rstn` in 1: reset, asynchronous, active-low.
- `wr_pvld` in 1: producer valid.
- `wr_prdy` out 1: producer ready.
- `wr_pd` in WIDTH: producer payload.
- `rd_pvld` out 1: consumer valid.
- `rd_prdy` in 1: consumer ready.
- `rd_pd` out WIDTH: consumer payload.
- `wr_count` out AW+1: total occupancy, 0..DEPTH.
- `ram_we` out 1: RAM write enable.
- `ram_wa` out AW: RAM write address.
- `ram_di` out WIDTH: RAM write data.
- `ram_re` out 1: RAM read enable; the address is latched on this edge.
- `ram_ra` out AW: RAM read address.
- `ram_dout` in WIDTH: RAM read data, valid the cycle after `ram_re`.
- `pwrbus_ram_pd` in 32: power control; forwarded unmodified on `ram_pwrbus_ram_pd`.
- `ram_pwrbus_ram_pd` out 32: to the RAM.

## Operation
- State:
  - `wr_ptr` and `rd_ptr` (AW bits, wrap mod DEPTH).
  - `ram_cnt` (entries in RAM not yet read-issued).
  - `inflight` (1 bit, a read was issued last cycle).
  - `skid_occ` (0..2).
  - `wr_count = ram_cnt + inflight + skid_occ`, registered.
- Push:
  - `push = wr_pvld & wr_prdy`.
  - `wr_prdy = (wr_count != DEPTH)`, decoded from registers only.
  - On push: `ram_we=1`, `ram_wa=wr_ptr`, `ram_di=wr_pd`, and `wr_ptr` increments.
- Pop: `pop = rd_pvld & rd_prdy`.
- Issue:
  - `issue = (ram_cnt != 0) & (skid_occ + inflight - pop < 2)`.
  - On issue: `ram_re=1`, `ram_ra=rd_ptr`, `rd_ptr` increments, `ram_cnt` decrements, and `inflight` is set for the next cycle.
- Output selection:
  - `rd_pvld = (skid_occ != 0) | inflight`.
  - `rd_pd` is the skid head if `skid_occ != 0`, else `ram_dout` (bypass).
  - Data arriving while `inflight` is set is written into the skid unless it is bypassed and popped in the same cycle.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Simultaneous push and issue: `ram_cnt` is unchanged and `wr_count` updates by `push - pop`.
- No same-address read/write hazard:
  - Issue uses the registered `ram_cnt`, so a word written in cycle N is first issuable in N+1.
  - `wr_count ≤ DEPTH` guarantees the write side never overwrites an unissued entry.
- Full (`wr_count==DEPTH`): `wr_prdy=0`, and `wr_pvld` is ignored.
  - A pop in the same cycle raises `wr_prdy` only in the next cycle.
- Empty (`wr_count==0`): `rd_pvld=0`, `ram_re=0`, and `rd_prdy` is ignored.
- `ram_we`/`ram_re` are 0 whenever the corresponding condition is false. `ram_wa`/`ram_ra` always show the current pointers.

## Timing
- Reset values:
  - `wr_prdy=1`, `rd_pvld=0`, `rd_pd=0`, `wr_count=0`.
  - `ram_we=0`, `ram_re=0`, `ram_wa=0`, `ram_ra=0`, `ram_di=wr_pd` (combinational).
  - Pointers, counts, `inflight` and skid contents are all 0.
- Asserting reset mid-operation discards all contents immediately and asynchronously. The first push after release writes address 0.
- Latency into an empty FIFO: push in cycle N, issue in N+1, `rd_pvld` with data in N+2 (bypass).
- Throughput: 1 word/cycle sustained with `rd_prdy` held high.
- Combinational paths:
  - `rd_prdy` → `ram_re`.
  - `ram_dout` → `rd_pd`.
  - `wr_pvld` → `ram_we`.
  - `wr_prdy` has no input-to-output path.

## Structure
- Shared package `nv_fifo_pkg`: the `DEPTH`/`WIDTH`/`AW` constants and the occupancy-width constant.
- One sub-module, `nv_fifo_skid2`:
  - 2-entry output skid with bypass.
  - Inputs: `in_vld`/`in_pd` from `inflight`/`ram_dout`.
  - Outputs: `rd_pvld`, `rd_pd`, `skid_occ`; also takes `rd_prdy`.
- Pointer/count logic stays in the top module.

## Test plan
- Reset: with `nvdla_core_rstn=0`, check `wr_prdy=1`, `rd_pvld=0`, `wr_count=0`, `ram_we=0`, `ram_re=0`. Assert reset mid-cycle and check outputs clear asynchronously.
- Single word: push 0x2A5A5 in cycle 0 with `rd_prdy=1`. Expect `ram_re=1` with `ram_ra=0` in cycle 1, then `rd_pvld=1` with `rd_pd=0x2A5A5` in cycle 2. `wr_count` goes 1, 1, then 0 in cycle 3.
- Fill and wrap: with `rd_prdy=0`, push values 0..129.
  - `wr_prdy=0` after the 128th accept, with `wr_count=128`.
  - Then drain and expect values 0..127 in order.
  - Refill 200 more words and check `ram_wa` wraps 127→0.
- Streaming: hold `wr_pvld=1` and `rd_prdy=1` for 300 words with an incrementing payload. After the 2-cycle fill, expect one pop per cycle with no bubbles, and `wr_count` steady at ≤2.
- Backpressure: drive random `rd_prdy` (50%) and random `wr_pvld` for 10k words. A scoreboard shows exact order with no drops or duplicates, the skid never overflows, and no `ram_re` is issued while `skid_occ + inflight - pop == 2`.
- Reset mid-stream: with 50 words stored, pulse `nvdla_core_rstn` low for 1 cycle. Expect `wr_count=0` and `rd_pvld=0`. The next push writes `ram_wa=0` and is read back correctly.
